// File: rtl/ahb_master.sv
// AHB-style burst master: turns one command into a pipelined single or
// incrementing burst of 1..8 beats, with write-data handshake and read capture.
module ahb_master #(
  parameter int unsigned BEAT_BYTES = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_len,
  input  logic [31:0] wdata,
  output logic        wdata_ack,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic        HTRANS,
  output logic        HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 3;
  localparam logic [AW-1:0] ADDR_STEP = AW'(BEAT_BYTES);
  localparam logic [AW-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_PIPE,
    S_LAST
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic          htrans_q, htrans_d;
  logic          hburst_q, hburst_d;
  logic [DW-1:0] hwdata_q, hwdata_d;

  // Write data is consumed exactly when a write address phase completes.
  assign wdata_ack   = htrans_q & hwrite_q & HREADY;

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HTRANS      = htrans_q;
  assign HBURST      = hburst_q;
  assign HWDATA      = hwdata_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      haddr_q       <= '0;
      hwrite_q      <= 1'b0;
      htrans_q      <= 1'b0;
      hburst_q      <= 1'b0;
      hwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      haddr_q       <= haddr_d;
      hwrite_q      <= hwrite_d;
      htrans_q      <= htrans_d;
      hburst_q      <= hburst_d;
      hwdata_q      <= hwdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    done_d        = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    haddr_d       = haddr_q;
    hwrite_d      = hwrite_q;
    htrans_d      = htrans_q;
    hburst_d      = hburst_q;
    hwdata_d      = hwdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_ADDR;
          haddr_d  = cmd_addr & WORD_MASK;
          hwrite_d = cmd_write;
          hburst_d = (cmd_len != '0);
          htrans_d = 1'b1;
          rem_d    = cmd_len;
        end
      end
      S_ADDR, S_PIPE: begin
        if (HREADY) begin
          // PIPE also retires the data phase of the previous beat on this edge.
          if (state_q == S_PIPE && !hwrite_q) begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
          end
          if (rem_q == '0) begin
            state_d  = S_LAST;
            htrans_d = 1'b0;
          end else begin
            state_d = S_PIPE;
            haddr_d = haddr_q + ADDR_STEP;
            rem_d   = rem_q - LW'(1);
          end
        end
      end
      S_LAST: begin
        if (HREADY) begin
          if (!hwrite_q) begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wdata_ack) begin
      hwdata_d = wdata;
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_ahb_master.sv
// Self-checking bench for ahb_master: beat-counting transaction model checked
// every cycle, directed scenarios pinned to literals, then randomized traffic.
module tb_ahb_master;

  localparam int unsigned BB = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] wdata;
  logic        wdata_ack;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        busy;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic        HTRANS;
  logic        HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  always #5 HCLK = ~HCLK;

  ahb_master #(.BEAT_BYTES(BB)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_ack(wdata_ack),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .busy(busy),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction model: a command is n beats; m_a address phases and m_d data
  // phases have completed so far.
  bit          m_active, m_write, m_burst, m_clean, m_done_p, m_rv_p, w_refresh;
  logic [31:0] m_base, m_rdata;
  int          m_n, m_a, m_d;
  logic [31:0] wbeat [8];

  logic [31:0] alog [$];
  logic [31:0] wlog [$];
  int          rv_cnt, done_cnt, ack_cnt;
  logic [31:0] rlast;
  bit          saw_done, s_htrans, s_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit e_htrans();
    return m_active && (m_a < m_n);
  endfunction

  function automatic bit e_dphase();
    return m_active && (m_d < m_a);
  endfunction

  task automatic model_reset();
    m_active = 0; m_write = 0; m_burst = 0; m_clean = 1;
    m_done_p = 0; m_rv_p = 0; m_n = 0; m_a = 0; m_d = 0;
  endtask

  task automatic check_outputs();
    chk("cmd_ready",   32'(cmd_ready),   32'(!m_active));
    chk("busy",        32'(busy),        32'(m_active));
    chk("HTRANS",      32'(HTRANS),      32'(e_htrans()));
    chk("done",        32'(done),        32'(m_done_p));
    chk("rdata_valid", 32'(rdata_valid), 32'(m_rv_p));
    chk("wdata_ack",   32'(wdata_ack),   32'(e_htrans() && m_write && HREADY));
    if (e_htrans()) chk("HADDR", HADDR, m_base + 32'(m_a * BB));
    if (m_active) begin
      chk("HWRITE", 32'(HWRITE), 32'(m_write));
      chk("HBURST", 32'(HBURST), 32'(m_burst));
    end
    if (e_dphase() && m_write) chk("HWDATA", HWDATA, wbeat[m_d]);
    if (m_rv_p) chk("rdata", rdata, m_rdata);
    if (m_clean) begin
      chk("rst_HADDR",  HADDR,  32'h0);
      chk("rst_HWDATA", HWDATA, 32'h0);
      chk("rst_rdata",  rdata,  32'h0);
      chk("rst_HWRITE", 32'(HWRITE), 32'h0);
      chk("rst_HBURST", 32'(HBURST), 32'h0);
    end
    if (done === 1'b1) begin done_cnt++; saw_done = 1; end
    if (rdata_valid === 1'b1) begin rv_cnt++; rlast = rdata; end
    if (wdata_ack === 1'b1) ack_cnt++;
    if (e_htrans() && HREADY) alog.push_back(HADDR);
    if (e_dphase() && m_write && HREADY) wlog.push_back(HWDATA);
    s_htrans = HTRANS;
    s_ready  = cmd_ready;
  endtask

  task automatic model_step();
    bit ht, dp;
    ht = e_htrans();
    dp = e_dphase();
    if (HRESET) begin
      model_reset();
      return;
    end
    m_done_p = 0;
    m_rv_p   = 0;
    if (!m_active) begin
      if (cmd_valid) begin
        m_active = 1; m_clean = 0;
        m_write  = cmd_write;
        m_base   = {cmd_addr[31:2], 2'b00};
        m_n      = int'(cmd_len) + 1;
        m_burst  = (cmd_len != 3'd0);
        m_a = 0; m_d = 0;
      end
    end else if (HREADY) begin
      if (dp) begin
        if (!m_write) begin m_rv_p = 1; m_rdata = HRDATA; end
        m_d++;
        if (m_d == m_n) begin m_done_p = 1; m_active = 0; end
      end
      if (ht) begin
        if (m_write) begin wbeat[m_a] = wdata; w_refresh = 1; end
        m_a++;
      end
    end
  endtask

  task automatic tick();
    #1 check_outputs();
    @(posedge HCLK);
    model_step();
    @(negedge HCLK);
    if (w_refresh) wdata = $urandom;
    w_refresh = 0;
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [2:0] len,
                         input logic [31:0] wd0, input logic [31:0] low_mask,
                         input int rst_at, output int done_i);
    alog.delete(); wlog.delete();
    rv_cnt = 0; done_cnt = 0; ack_cnt = 0; saw_done = 0; done_i = -1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    wdata = wd0; HREADY = 1; HRESET = 0;
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 40; i++) begin
      HREADY = (i < 32) ? !low_mask[i] : 1'b1;
      HRESET = (i == rst_at);
      tick();
      HRESET = 0;
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_abort_HTRANS", 32'(s_htrans), 32'h0);
        chk("rst_abort_ready",  32'(s_ready),  32'h1);
      end
      if (saw_done && done_i < 0) done_i = i;
      if (done_i >= 0 || (rst_at >= 0 && i >= rst_at + 4)) break;
    end
    if (rst_at < 0 && done_i < 0) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no done within 40 cycles, expected one");
    end
    HREADY = 1;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int di;
    HRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wdata = 0; HRDATA = 0; HREADY = 1; w_refresh = 0;
    model_reset();
    @(negedge HCLK);
    tick();
    tick();
    HRESET = 0;
    tick();

    // Single write
    run_cmd(1'b1, 32'h10, 3'd0, 32'hDEADBEEF, 32'h0, -1, di);
    chk("sw_done_cycle", 32'(di), 32'd2);
    chk("sw_naddr",  32'(alog.size()), 32'd1);
    chk("sw_addr0",  (alog.size() > 0) ? alog[0] : 32'hx, 32'h10);
    chk("sw_hwdata", (wlog.size() > 0) ? wlog[0] : 32'hx, 32'hDEADBEEF);
    chk("sw_acks",   32'(ack_cnt),  32'd1);
    chk("sw_dones",  32'(done_cnt), 32'd1);

    // Single read
    HRDATA = 32'h12345678;
    run_cmd(1'b0, 32'h20, 3'd0, 32'h0, 32'h0, -1, di);
    chk("sr_rdata", rlast, 32'h12345678);
    chk("sr_rv",    32'(rv_cnt),   32'd1);
    chk("sr_dones", 32'(done_cnt), 32'd1);

    // Four-beat write burst
    run_cmd(1'b1, 32'h100, 3'd3, 32'hA5A5_0001, 32'h0, -1, di);
    chk("wb_naddr", 32'(alog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("wb_addr", (alog.size() > i) ? alog[i] : 32'hx, 32'h100 + 32'(4 * i));
    chk("wb_acks", 32'(ack_cnt), 32'd4);
    chk("wb_done_cycle", 32'(di), 32'd5);

    // Three-beat read burst with wait states on beat 2
    HRDATA = $urandom;
    run_cmd(1'b0, 32'h200, 3'd2, 32'h0, 32'hC, -1, di);
    chk("rb_naddr", 32'(alog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("rb_addr", (alog.size() > i) ? alog[i] : 32'hx, 32'h200 + 32'(4 * i));
    chk("rb_rv", 32'(rv_cnt), 32'd3);

    // Address wrap
    run_cmd(1'b1, 32'hFFFF_FFFF, 3'd1, 32'h1111_2222, 32'h0, -1, di);
    chk("wrap_addr0", (alog.size() > 0) ? alog[0] : 32'hx, 32'hFFFF_FFFC);
    chk("wrap_addr1", (alog.size() > 1) ? alog[1] : 32'hx, 32'h0000_0000);

    // Reset during beat 2 of an eight-beat read
    run_cmd(1'b0, 32'h400, 3'd7, 32'h0, 32'h0, 1, di);
    chk("rst_dones", 32'(done_cnt), 32'd0);
    chk("rst_rv",    32'(rv_cnt),   32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      HRESET    = ($urandom_range(0, 299) == 0);
      HREADY    = ($urandom_range(0, 9) < 7);
      HRDATA    = $urandom;
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_len   = 3'($urandom_range(0, 7));
      cmd_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameter: BEAT_BYTES, default 4, address increment per burst beat.
REQ-002 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-003 HCLK  in  1  clock; all logic on its rising edge.
REQ-004 HRESET  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accept; high only in IDLE.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  32  start byte address; bits [1:0] SHALL be forced to 00.
REQ-009 cmd_len  in  3  number of beats minus 1 (1..8 beats).
REQ-010 wdata  in  32  write data for the current beat; upstream holds it valid until wdata_ack.
REQ-011 wdata_ack  out  1  wdata consumed this cycle.
REQ-012 rdata  out  32  captured read data.
REQ-013 rdata_valid  out  1  one-cycle pulse per completed read beat.
REQ-014 done  out  1  one-cycle pulse when the last beat's data phase completes.
REQ-015 busy  out  1  high when not in IDLE.
REQ-016 HADDR  out  32  bus address; bit 31 is used for slave decode.
REQ-017 HWRITE  out  1  bus direction.
REQ-018 HTRANS  out  1  1 = active transfer, 0 = idle.
REQ-019 HBURST  out  1  1 = incrementing burst (cmd_len != 0), 0 = single.
REQ-020 HWDATA  out  32  write data for the data phase.
REQ-021 HRDATA  in  32  read data from the slave.
REQ-022 HREADY  in  1  slave ready; a phase completes on a rising edge where HREADY = 1.

Function
REQ-023 States SHALL be IDLE, ADDR (first address phase only), PIPE (data phase of beat n overlapped with address phase of beat n+1), and LAST (final data phase only).
REQ-024 In IDLE, a cmd_valid sampled high SHALL latch the write flag, the address and the length, and the FSM SHALL enter ADDR on the next cycle.
REQ-025 In ADDR, the block SHALL drive HTRANS=1, HADDR=the latched address, HWRITE, and HBURST; the FSM SHALL advance on HREADY=1 to PIPE if beats remain, else to LAST.
REQ-026 On each address-phase completion, the next HADDR SHALL equal the previous HADDR + BEAT_BYTES, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-027 In PIPE with HREADY=1, the current data phase and the next address phase SHALL complete on the same edge; the FSM SHALL go to LAST after the final address has been issued.
REQ-028 In LAST, the block SHALL drive HTRANS=0; on HREADY=1 it SHALL pulse done and return to IDLE.
REQ-029 While HREADY=0, HADDR, HTRANS, HWRITE, HBURST and HWDATA SHALL hold stable, and no beat SHALL be counted.
REQ-030 For writes, wdata_ack SHALL equal HTRANS & HWRITE & HREADY, and wdata SHALL be registered into HWDATA on that edge for the following data phase.
REQ-031 For reads, on a data-phase completion HRDATA SHALL be captured into rdata and rdata_valid SHALL pulse on the next cycle.
REQ-032 Exactly cmd_len+1 address phases and cmd_len+1 data phases SHALL occur per command.
REQ-033 cmd_ready SHALL be low while busy; back-to-back commands SHALL have at least one IDLE cycle (HTRANS=0) between them.
REQ-034 cmd_valid while busy SHALL be ignored.

Reset
REQ-035 While HRESET=1 at a rising edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 except cmd_ready=1.
REQ-036 A reset mid-burst SHALL abort the burst with no further done, rdata_valid or wdata_ack pulses.

Verification
REQ-037 Single write: addr 0x00000010, len 0, wdata 0xDEADBEEF, HREADY=1 -> HADDR=0x10 with HTRANS=1 for 1 cycle, then HWDATA=0xDEADBEEF, done on the 3rd cycle after accept.
REQ-038 Single read: addr 0x20, HRDATA=0x12345678 -> rdata=0x12345678 with a single rdata_valid pulse, plus a done pulse.
REQ-039 Write burst of 4 beats at 0x100 -> HADDR sequence 0x100, 0x104, 0x108, 0x10C on consecutive cycles, HBURST=1, 4 wdata_ack pulses.
REQ-040 Read burst of 3 beats with HREADY=0 for 2 cycles during beat 2 -> bus outputs held, 3 rdata_valid pulses, addresses unchanged.
REQ-041 Burst of 2 beats at 0xFFFFFFFC -> second HADDR=0x00000000.
REQ-042 HRESET asserted during beat 2 of an 8-beat read -> next cycle HTRANS=0, cmd_ready=1, no done pulse.
